// File: rtl/scene_restore_pipe.sv
// Scene-radiance restoration stage: J = (I - A) * (1/t) + A per channel.
// Three register stages under one global enable with valid/ready flow control.
// Rounding is half-up, results saturate to [0, 2^DW-1], and bypass passes I through.
// o_sat_cnt counts delivered pixels that had at least one clipped channel.
module scene_restore_pipe #(
  parameter int                 DW         = 8,
  parameter int                 CH         = 3,
  parameter int                 INV_T_W    = 8,
  parameter int                 INV_T_FRAC = 4,
  parameter logic [INV_T_W-1:0] INV_T_MAX  = 8'hA0,
  parameter int                 CNT_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CH*DW-1:0]     i_pix,
  input  logic [CH*DW-1:0]     i_atm,
  input  logic [INV_T_W-1:0]   i_inv_t,
  input  logic                 i_bypass,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CH*DW-1:0]     o_pix,
  input  logic                 i_cnt_clr,
  output logic [CNT_W-1:0]     o_sat_cnt
);

  // Product width: signed (DW+1)-bit difference times zero-extended 1/t.
  localparam int PW = DW + INV_T_W + 2;
  localparam logic [INV_T_W-1:0] INV_T_ONE = INV_T_W'(1) << INV_T_FRAC;
  localparam logic signed [PW-1:0] RND  = PW'(1) << (INV_T_FRAC - 1);
  localparam logic signed [PW-1:0] JMAX = PW'((1 << DW) - 1);

  logic                 w_en;
  logic [INV_T_W-1:0]   w_inv_clamp;
  logic [CH*DW-1:0]     w_pix3;
  logic [CH-1:0]        w_sat;

  logic                 r_v1, r_v2, r_v3;
  logic [INV_T_W-1:0]   r_inv1;
  logic                 r_byp1, r_byp2;
  logic [CH*DW-1:0]     r_i1, r_a1, r_i2, r_a2;
  logic [CH*DW-1:0]     r_pix3;
  logic                 r_sat3;
  logic [CNT_W-1:0]     r_cnt;

  // Whole pipe advances together; it only freezes when the output is stuck.
  assign w_en    = !r_v3 | i_ready;
  assign o_ready = w_en;
  assign o_valid = r_v3;
  assign o_pix   = r_pix3;
  assign o_sat_cnt = r_cnt;

  // Clamp 1/t into [1.0, INV_T_MAX]; t > 1 is not physical and would darken the scene.
  always_comb begin
    w_inv_clamp = i_inv_t;
    if (i_inv_t < INV_T_ONE) begin
      w_inv_clamp = INV_T_ONE;
    end else if (i_inv_t > INV_T_MAX) begin
      w_inv_clamp = INV_T_MAX;
    end
  end

  // Stage valid chain; bubbles advance whenever the pipe is enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Side-band data carried alongside each pixel: I, A, clamped 1/t and bypass.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inv1 <= '0;
      r_byp1 <= 1'b0;
      r_byp2 <= 1'b0;
      r_i1   <= '0;
      r_a1   <= '0;
      r_i2   <= '0;
      r_a2   <= '0;
    end else if (w_en) begin
      r_inv1 <= w_inv_clamp;
      r_byp1 <= i_bypass;
      r_byp2 <= r_byp1;
      r_i1   <= i_pix;
      r_a1   <= i_atm;
      r_i2   <= r_i1;
      r_a2   <= r_a1;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [DW:0]   w_d;
    logic signed [DW:0]   r_d1;
    logic signed [PW-1:0] r_p2;
    logic signed [PW-1:0] w_r;
    logic signed [PW-1:0] w_j;
    logic [DW-1:0]        w_ch;
    logic                 w_flag;

    assign w_d = $signed({1'b0, i_pix[gi*DW +: DW]}) - $signed({1'b0, i_atm[gi*DW +: DW]});

    // S1 captures the signed difference, S2 the scaled product.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_d1 <= '0;
        r_p2 <= '0;
      end else if (w_en) begin
        r_d1 <= w_d;
        r_p2 <= PW'(r_d1) * PW'($signed({1'b0, r_inv1}));
      end
    end

    // Arithmetic shift after adding half an LSB rounds half up for both signs.
    assign w_r = (r_p2 + RND) >>> INV_T_FRAC;
    assign w_j = w_r + $signed(PW'(r_a2[gi*DW +: DW]));

    // Saturate to the channel range unless the pixel is bypassed.
    always_comb begin
      w_ch   = w_j[DW-1:0];
      w_flag = 1'b0;
      if (r_byp2) begin
        w_ch = r_i2[gi*DW +: DW];
      end else if (w_j[PW-1]) begin
        w_ch   = '0;
        w_flag = 1'b1;
      end else if (w_j > JMAX) begin
        w_ch   = '1;
        w_flag = 1'b1;
      end
    end

    assign w_pix3[gi*DW +: DW] = w_ch;
    assign w_sat[gi]           = w_flag;
  end

  // S3 output register; the saturation flag travels with its pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix3 <= '0;
      r_sat3 <= 1'b0;
    end else if (w_en) begin
      r_pix3 <= w_pix3;
      r_sat3 <= |w_sat;
    end
  end

  // Count saturated pixels once, on delivery; clear wins, count sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (r_v3 && i_ready && r_sat3 && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_scene_restore_pipe.sv
// Bench for scene_restore_pipe: directed test-plan pixels, a random stream
// under backpressure, mid-stream reset and counter clear.
module tb_scene_restore_pipe;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_pix;
  logic [23:0] i_atm;
  logic [7:0]  i_inv_t;
  logic        i_bypass;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_pix;
  logic        i_cnt_clr;
  logic [15:0] o_sat_cnt;

  scene_restore_pipe dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_pix     (i_pix),
    .i_atm     (i_atm),
    .i_inv_t   (i_inv_t),
    .i_bypass  (i_bypass),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_pix     (o_pix),
    .i_cnt_clr (i_cnt_clr),
    .o_sat_cnt (o_sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    bit          sat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_cnt    = 0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_pix   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int floor_div16(input int x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  // Reference: J = (I-A)/t + A with 1/t limited to [1.0, 10.0], rounded, clipped.
  function automatic exp_t model(input logic [23:0] p, input logic [23:0] a,
                                 input logic [7:0] inv, input bit byp);
    exp_t e;
    int t;
    e.pix = '0;
    e.sat = 1'b0;
    t = int'(inv);
    if (t < 16)  t = 16;
    if (t > 160) t = 160;
    for (int c = 0; c < 3; c++) begin
      int ii, aa, j;
      ii = int'(p[c*8 +: 8]);
      aa = int'(a[c*8 +: 8]);
      if (byp) begin
        j = ii;
      end else begin
        j = floor_div16((ii - aa) * t + 8) + aa;
        if (j < 0)   begin j = 0;   e.sat = 1'b1; end
        if (j > 255) begin j = 255; e.sat = 1'b1; end
      end
      e.pix[c*8 +: 8] = 8'(j);
    end
    return e;
  endfunction

  // One clock cycle: drive, sample mid-cycle, score transfers, advance to next edge.
  task automatic cycle(input bit v, input logic [23:0] p, input logic [23:0] a,
                       input logic [7:0] inv, input bit b, input bit r, input bit c,
                       output bit acc);
    exp_t e;
    bit   out_x;
    bit   inc;
    i_valid = v; i_pix = p; i_atm = a; i_inv_t = inv; i_bypass = b;
    i_ready = r; i_cnt_clr = c;
    #1;
    chk("o_ready", 32'(o_ready), 32'(!o_valid || r));
    chk("sat_cnt", 32'(o_sat_cnt), 32'(m_cnt));
    if (prev_stall) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_pix", 32'(o_pix), 32'(prev_pix));
    end
    acc   = v && o_ready;
    out_x = o_valid && r;
    inc   = 1'b0;
    if (out_x) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("pix", 32'(o_pix), 32'(e.pix));
        inc = e.sat;
      end
    end
    if (c) m_cnt = 0;
    else if (inc && m_cnt != 65535) m_cnt++;
    if (acc) sb.push_back(model(p, a, inv, b));
    prev_stall = o_valid && !r;
    prev_pix   = o_pix;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r);
    bit acc;
    cycle(1'b0, 24'h0, 24'h0, 8'h0, 1'b0, r, 1'b0, acc);
  endtask

  // Single pixel into an empty pipe: check 3-cycle latency and the plan's value.
  task automatic send_one(input string tag, input logic [23:0] p, input logic [23:0] a,
                          input logic [7:0] inv, input bit b, input logic [23:0] exp_pix,
                          input bit clr_on_out);
    bit acc;
    int lat;
    cycle(1'b1, p, a, inv, b, 1'b1, 1'b0, acc);
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    lat = 1;
    while (!o_valid && lat < 10) begin
      idle(1'b1);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_value"}, 32'(o_pix), 32'(exp_pix));
    cycle(1'b0, 24'h0, 24'h0, 8'h0, 1'b0, 1'b1, clr_on_out, acc);
  endtask

  logic [23:0] rp [8];
  logic [23:0] ra [8];
  logic [7:0]  rinv [8];
  bit          rb [8];

  initial begin
    bit acc;
    int idx;
    bit rdy;
    i_rst = 1'b1; i_valid = 1'b0; i_pix = '0; i_atm = '0; i_inv_t = '0;
    i_bypass = 1'b0; i_ready = 1'b0; i_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pix", 32'(o_pix), 32'd0);
    chk("rst_cnt", 32'(o_sat_cnt), 32'd0);
    #2 i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed test-plan pixels.
    send_one("basic", {3{8'd100}}, {3{8'd90}}, 8'h20, 1'b0, {3{8'd110}}, 1'b0);
    chk("basic_cnt", 32'(o_sat_cnt), 32'd0);
    send_one("round_pos", {3{8'd101}}, {3{8'd90}}, 8'h14, 1'b0, {3{8'd104}}, 1'b0);
    send_one("round_neg", {3{8'd79}},  {3{8'd90}}, 8'h14, 1'b0, {3{8'd76}},  1'b0);
    send_one("sat", {8'd50, 8'd200, 8'd20}, {8'd50, 8'd10, 8'd90}, 8'h20, 1'b0,
             {8'd50, 8'd255, 8'd0}, 1'b0);
    chk("sat_cnt_one", 32'(o_sat_cnt), 32'd1);
    send_one("clamp_lo", {3{8'd100}}, {3{8'd90}}, 8'h08, 1'b0, {3{8'd100}}, 1'b0);
    send_one("clamp_hi", {3{8'd100}}, {3{8'd90}}, 8'hFF, 1'b0, {3{8'd190}}, 1'b0);
    send_one("bypass", {3{8'd200}}, {3{8'd10}}, 8'h20, 1'b1, {3{8'd200}}, 1'b0);
    chk("bypass_cnt", 32'(o_sat_cnt), 32'd1);

    // Random stream with i_ready toggling 1,0,0,1,...
    for (int k = 0; k < 8; k++) begin
      rp[k]   = 24'($urandom());
      ra[k]   = 24'($urandom());
      rinv[k] = 8'($urandom_range(0, 255));
      rb[k]   = ($urandom_range(0, 5) == 0);
    end
    idx = 0;
    for (int cyc = 0; cyc < 200 && (idx < 8 || sb.size() > 0); cyc++) begin
      rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (idx < 8) begin
        cycle(1'b1, rp[idx], ra[idx], rinv[idx], rb[idx], rdy, 1'b0, acc);
        if (acc) idx++;
      end else begin
        cycle(1'b0, 24'h0, 24'h0, 8'h0, 1'b0, rdy, 1'b0, acc);
      end
    end
    chk("stream_sent", 32'(idx), 32'd8);
    chk("stream_drained", 32'(sb.size()), 32'd0);
    idle(1'b1);

    // Reset with three pixels in flight.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 24'($urandom()), 24'($urandom()), 8'h30, 1'b0, 1'b1, 1'b0, acc);
    end
    #1 i_rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_pix", 32'(o_pix), 32'd0);
    chk("midrst_cnt", 32'(o_sat_cnt), 32'd0);
    sb.delete();
    m_cnt = 0;
    prev_stall = 1'b0;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 i_rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_idle", 32'(o_valid), 32'd0);
      idle(1'b1);
    end

    // Counter clear coincident with a saturating output transfer.
    send_one("sat_a", {3{8'd250}}, {3{8'd10}}, 8'h40, 1'b0, {3{8'd255}}, 1'b0);
    chk("sat_a_cnt", 32'(o_sat_cnt), 32'd1);
    send_one("sat_b", {3{8'd5}}, {3{8'd200}}, 8'h40, 1'b0, {3{8'd0}}, 1'b1);
    chk("clr_wins", 32'(o_sat_cnt), 32'd0);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
